// File: rtl/peripheral_apb4_pkg.sv
// Shared APB4 definitions: bus widths, transfer-phase encoding and fixed protection attributes.
package peripheral_apb4_pkg;

    localparam int unsigned HADDR_SIZE = 32;
    localparam int unsigned HDATA_SIZE = 32;

    localparam logic [2:0] PPROT_DEFAULT = 3'b000;

    typedef enum logic [1:0] {
        APB_IDLE,
        APB_SETUP,
        APB_ACCESS
    } apb4_state_t;

    // Round-robin successor of a requester index.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1) % n;
    endfunction

endpackage

// File: rtl/peripheral_apb4_master_arbiter_if.sv
// APB4 bus bundle between the arbiter (master side) and the peripheral bus (slave side).
interface peripheral_apb4_master_arbiter_if
    import peripheral_apb4_pkg::*;
#(
    parameter int unsigned ADDR_W = HADDR_SIZE,
    parameter int unsigned DATA_W = HDATA_SIZE
);

    logic                  PSEL;
    logic                  PENABLE;
    logic [ADDR_W-1:0]     PADDR;
    logic                  PWRITE;
    logic [DATA_W-1:0]     PWDATA;
    logic [DATA_W/8-1:0]   PSTRB;
    logic [2:0]            PPROT;
    logic                  PREADY;
    logic [DATA_W-1:0]     PRDATA;
    logic                  PSLVERR;

    modport master (
        output PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB, PPROT,
        input  PREADY, PRDATA, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB, PPROT,
        output PREADY, PRDATA, PSLVERR
    );

endinterface

// File: rtl/peripheral_apb4_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping to index 0.
module peripheral_apb4_rr_arbiter #(
    parameter  int unsigned NREQ  = 4,
    localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  gnt_next,
    output logic [IDX_W-1:0] index
);

    logic [IDX_W-1:0] pos;
    logic             found;

    always_comb begin
        gnt_next = '0;
        index    = '0;
        found    = 1'b0;
        pos      = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            pos = IDX_W'((32'(ptr) + k) % NREQ);
            if (!found && req[pos]) begin
                found         = 1'b1;
                gnt_next[pos] = 1'b1;
                index         = pos;
            end
        end
    end

endmodule

// File: rtl/peripheral_apb4_master_arbiter.sv
// Shares one APB4 master port among NREQ requesters with round-robin arbitration and
// sequences the SETUP/ACCESS phases, returning read data and slave error to the owner.
module peripheral_apb4_master_arbiter
    import peripheral_apb4_pkg::*;
#(
    parameter int unsigned NREQ   = 4,
    parameter int unsigned ADDR_W = HADDR_SIZE,
    parameter int unsigned DATA_W = HDATA_SIZE
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            req,
    input  logic [NREQ*ADDR_W-1:0]     req_addr,
    input  logic [NREQ-1:0]            req_write,
    input  logic [NREQ*DATA_W-1:0]     req_wdata,
    input  logic [NREQ*DATA_W/8-1:0]   req_strb,
    output logic [NREQ-1:0]            gnt,
    output logic [NREQ-1:0]            done,
    output logic [DATA_W-1:0]          rdata,
    output logic                       err,
    peripheral_apb4_master_arbiter_if.master apb
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned IDX_W  = (NREQ > 1) ? $clog2(NREQ) : 1;

    apb4_state_t         state_q, state_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [NREQ-1:0]     gnt_q, gnt_d;
    logic [NREQ-1:0]     done_q, done_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic                pwrite_q, pwrite_d;
    logic [DATA_W-1:0]   pwdata_q, pwdata_d;
    logic [STRB_W-1:0]   pstrb_q, pstrb_d;

    logic [NREQ-1:0]     eligible;
    logic [NREQ-1:0]     arb_gnt;
    logic [IDX_W-1:0]    arb_idx;

    // A requester whose done is showing still holds req this cycle; keep it out of the race.
    assign eligible = req & ~done_q;

    peripheral_apb4_rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr_arbiter (
        .req      (eligible),
        .ptr      (ptr_q),
        .gnt_next (arb_gnt),
        .index    (arb_idx)
    );

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        gnt_d    = gnt_q;
        done_d   = '0;
        rdata_d  = rdata_q;
        err_d    = err_q;
        paddr_d  = paddr_q;
        pwrite_d = pwrite_q;
        pwdata_d = pwdata_q;
        pstrb_d  = pstrb_q;
        unique case (state_q)
            APB_IDLE: begin
                if (|arb_gnt) begin
                    gnt_d    = arb_gnt;
                    ptr_d    = IDX_W'(rr_next(32'(arb_idx), NREQ));
                    paddr_d  = req_addr[32'(arb_idx)*ADDR_W +: ADDR_W];
                    pwrite_d = req_write[arb_idx];
                    pwdata_d = req_wdata[32'(arb_idx)*DATA_W +: DATA_W];
                    pstrb_d  = req_write[arb_idx] ? req_strb[32'(arb_idx)*STRB_W +: STRB_W] : '0;
                    state_d  = APB_SETUP;
                end
            end
            APB_SETUP: begin
                state_d = APB_ACCESS;
            end
            APB_ACCESS: begin
                if (apb.PREADY) begin
                    if (!pwrite_q) begin
                        rdata_d = apb.PRDATA;
                    end
                    err_d   = apb.PSLVERR;
                    done_d  = gnt_q;
                    gnt_d   = '0;
                    state_d = APB_IDLE;
                end
            end
            default: begin
                gnt_d   = '0;
                state_d = APB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= APB_IDLE;
            ptr_q    <= '0;
            gnt_q    <= '0;
            done_q   <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            paddr_q  <= '0;
            pwrite_q <= 1'b0;
            pwdata_q <= '0;
            pstrb_q  <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            paddr_q  <= paddr_d;
            pwrite_q <= pwrite_d;
            pwdata_q <= pwdata_d;
            pstrb_q  <= pstrb_d;
        end
    end

    assign gnt         = gnt_q;
    assign done        = done_q;
    assign rdata       = rdata_q;
    assign err         = err_q;
    assign apb.PSEL    = (state_q != APB_IDLE);
    assign apb.PENABLE = (state_q == APB_ACCESS);
    assign apb.PADDR   = paddr_q;
    assign apb.PWRITE  = pwrite_q;
    assign apb.PWDATA  = pwdata_q;
    assign apb.PSTRB   = pstrb_q;
    assign apb.PPROT   = PPROT_DEFAULT;

endmodule

// File: tb/tb_peripheral_apb4_master_arbiter.sv
// Directed bench for the APB4 round-robin master arbiter with a transaction-level reference model.
module tb_peripheral_apb4_master_arbiter;
    import peripheral_apb4_pkg::*;

    localparam int NREQ = 4;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int SW   = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NREQ-1:0]    req       = '0;
    logic [NREQ-1:0]    req_write = '0;
    logic [NREQ*AW-1:0] req_addr  = '0;
    logic [NREQ*DW-1:0] req_wdata = '0;
    logic [NREQ*SW-1:0] req_strb  = '0;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    done;
    logic [DW-1:0]      rdata;
    logic               err;

    peripheral_apb4_master_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) apb ();

    peripheral_apb4_master_arbiter #(
        .NREQ   (NREQ),
        .ADDR_W (AW),
        .DATA_W (DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_addr  (req_addr),
        .req_write (req_write),
        .req_wdata (req_wdata),
        .req_strb  (req_strb),
        .gnt       (gnt),
        .done      (done),
        .rdata     (rdata),
        .err       (err),
        .apb       (apb)
    );

    // Slave: PREADY after slv_wait ACCESS wait states.
    int          slv_wait  = 0;
    logic [31:0] slv_rdata = '0;
    logic        slv_err   = 1'b0;
    int          acc_cnt;

    assign apb.PREADY  = apb.PSEL && apb.PENABLE && (acc_cnt >= slv_wait);
    assign apb.PRDATA  = slv_rdata;
    assign apb.PSLVERR = slv_err;

    always @(posedge clk or posedge rst) begin
        if (rst) acc_cnt <= 0;
        else if (apb.PSEL && apb.PENABLE && !apb.PREADY) acc_cnt <= acc_cnt + 1;
        else acc_cnt <= 0;
    end

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: owner index (-1 = bus free), phase age since grant, captured transfer.
    int          m_owner = -1;
    int          m_age   = 0;
    int          m_ptr   = 0;
    logic [3:0]  m_done  = '0;
    logic [31:0] m_rdata = '0;
    logic        m_err   = 1'b0;
    logic [31:0] m_addr  = '0;
    logic [31:0] m_wdata = '0;
    logic        m_write = 1'b0;
    logic [3:0]  m_strb  = '0;

    task automatic model_step();
        logic [NREQ-1:0] nd;
        nd = '0;
        if (rst) begin
            m_owner = -1; m_age = 0; m_ptr = 0; m_done = '0; m_rdata = '0; m_err = 1'b0;
            m_addr = '0; m_wdata = '0; m_write = 1'b0; m_strb = '0;
            return;
        end
        if (m_owner >= 0) begin
            if (m_age >= 2 && apb.PREADY) begin
                nd[m_owner] = 1'b1;
                if (!m_write) m_rdata = apb.PRDATA;
                m_err   = apb.PSLVERR;
                m_owner = -1;
            end else begin
                m_age++;
            end
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                int i;
                i = (m_ptr + k) % NREQ;
                if (req[i] && !m_done[i]) begin
                    m_owner = i;
                    m_age   = 1;
                    m_addr  = req_addr[i*AW +: AW];
                    m_write = req_write[i];
                    m_wdata = req_wdata[i*DW +: DW];
                    m_strb  = req_write[i] ? req_strb[i*SW +: SW] : 4'b0000;
                    m_ptr   = (i + 1) % NREQ;
                    break;
                end
            end
        end
        m_done = nd;
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        model_step();
    end

    logic        prev_psel  = 1'b0;
    logic [31:0] prev_paddr = '0;
    logic [31:0] prev_pwdata = '0;
    logic [3:0]  prev_pstrb = '0;
    logic        prev_pwrite = 1'b0;

    task automatic compare();
        logic [3:0] e_gnt;
        e_gnt = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
        chk("gnt", gnt, e_gnt);
        chk("done", done, m_done);
        chk("PSEL", apb.PSEL, m_owner >= 0);
        chk("PENABLE", apb.PENABLE, (m_owner >= 0) && (m_age >= 2));
        chk("PPROT", apb.PPROT, 3'b000);
        chk("gnt_onehot", $countones(gnt) <= 1, 1'b1);
        if (m_owner >= 0) begin
            chk("PADDR", apb.PADDR, m_addr);
            chk("PWRITE", apb.PWRITE, m_write);
            chk("PWDATA", apb.PWDATA, m_wdata);
            chk("PSTRB", apb.PSTRB, m_strb);
        end
        if (|m_done) begin
            chk("rdata", rdata, m_rdata);
            chk("err", err, m_err);
        end
        if (!rst && prev_psel && apb.PENABLE) begin
            chk("stable_PADDR", apb.PADDR, prev_paddr);
            chk("stable_PWDATA", apb.PWDATA, prev_pwdata);
            chk("stable_PSTRB", apb.PSTRB, prev_pstrb);
            chk("stable_PWRITE", apb.PWRITE, prev_pwrite);
        end
        prev_psel   = apb.PSEL;
        prev_paddr  = apb.PADDR;
        prev_pwdata = apb.PWDATA;
        prev_pstrb  = apb.PSTRB;
        prev_pwrite = apb.PWRITE;
    endtask

    initial forever begin
        @(negedge clk);
        compare();
    end

    task automatic run_txn(input int idx, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [3:0] st, input int wt,
                           input logic [31:0] prd, input logic perr,
                           input logic [31:0] exp_rdata, input logic exp_err, input string tag);
        logic ok;
        ok        = 1'b0;
        slv_wait  = wt;
        slv_rdata = prd;
        slv_err   = perr;
        req_addr[idx*AW +: AW]  = addr;
        req_wdata[idx*DW +: DW] = wd;
        req_strb[idx*SW +: SW]  = st;
        req_write[idx]          = wr;
        req[idx]                = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (done[idx]) begin
                ok = 1'b1;
                break;
            end
        end
        chk({tag, "_done_seen"}, ok, 1'b1);
        if (ok) begin
            chk({tag, "_rdata"}, rdata, exp_rdata);
            chk({tag, "_err"}, err, exp_err);
        end
        req[idx] = 1'b0;
    endtask

    initial begin
        int acc;
        int nd;
        int seen;
        logic [3:0] prevg;
        int gidx[$];
        int gcyc[$];

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_gnt", gnt, 4'b0000);
        chk("rst_done", done, 4'b0000);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_err", err, 1'b0);
        chk("rst_PSEL", apb.PSEL, 1'b0);
        chk("rst_PENABLE", apb.PENABLE, 1'b0);
        chk("rst_PADDR", apb.PADDR, 32'h0);
        chk("rst_PWDATA", apb.PWDATA, 32'h0);
        chk("rst_PSTRB", apb.PSTRB, 4'h0);
        chk("rst_PWRITE", apb.PWRITE, 1'b0);
        #1 rst = 1'b0;

        // Single zero-wait read on requester 0
        @(negedge clk);
        slv_wait = 0; slv_rdata = 32'hDEAD_BEEF; slv_err = 1'b0;
        req_addr[0 +: AW] = 32'h1000_0040;
        req_write[0] = 1'b0;
        req[0] = 1'b1;
        @(negedge clk);
        chk("t1_setup_PSEL", apb.PSEL, 1'b1);
        chk("t1_setup_PENABLE", apb.PENABLE, 1'b0);
        chk("t1_setup_gnt", gnt, 4'b0001);
        chk("t1_setup_PADDR", apb.PADDR, 32'h1000_0040);
        @(negedge clk);
        chk("t1_access_PENABLE", apb.PENABLE, 1'b1);
        chk("t1_access_done", done, 4'b0000);
        @(negedge clk);
        chk("t1_done", done, 4'b0001);
        chk("t1_rdata", rdata, 32'hDEAD_BEEF);
        chk("t1_err", err, 1'b0);
        chk("t1_PSEL_low", apb.PSEL, 1'b0);
        req[0] = 1'b0;
        @(negedge clk);
        chk("t1_done_pulse", done, 4'b0000);

        // Write with three wait states on requester 2
        slv_wait = 3;
        req_addr[2*AW +: AW]  = 32'h2000_0008;
        req_wdata[2*DW +: DW] = 32'hA5A5_0001;
        req_strb[2*SW +: SW]  = 4'b0011;
        req_write[2] = 1'b1;
        req[2] = 1'b1;
        acc = 0;
        nd  = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (apb.PENABLE) begin
                acc++;
                chk("t2_PSTRB", apb.PSTRB, 4'b0011);
                chk("t2_PWDATA", apb.PWDATA, 32'hA5A5_0001);
                chk("t2_PADDR", apb.PADDR, 32'h2000_0008);
            end
            if (done[2]) begin
                nd++;
                req[2] = 1'b0;
            end
        end
        chk("t2_access_cycles", acc, 4);
        chk("t2_done_count", nd, 1);

        // Slave error on a read, then a clean write reports err=0 and keeps rdata
        run_txn(0, 1'b0, 32'h1000_0100, 32'h0, 4'hF, 0, 32'h1234_5678, 1'b1,
                32'h1234_5678, 1'b1, "t3_slverr");
        run_txn(3, 1'b1, 32'h1000_0200, 32'hCAFE_0003, 4'b1100, 1, 32'h5555_AAAA, 1'b0,
                32'h1234_5678, 1'b0, "t3_clean");

        // Requester input change during ACCESS is ignored
        slv_wait = 2; slv_rdata = 32'h0BAD_F00D; slv_err = 1'b0;
        req_addr[1*AW +: AW] = 32'h3000_0010;
        req_write[1] = 1'b0;
        req[1] = 1'b1;
        seen = 0;
        for (int c = 0; c < 20 && seen == 0; c++) begin
            @(negedge clk);
            if (apb.PENABLE) seen = 1;
        end
        chk("t4_access_reached", seen, 1);
        req_addr[1*AW +: AW] = 32'hFFFF_FFF0;
        req_write[1] = 1'b1;
        @(negedge clk);
        chk("t4_PADDR_held", apb.PADDR, 32'h3000_0010);
        chk("t4_PWRITE_held", apb.PWRITE, 1'b0);
        seen = 0;
        for (int c = 0; c < 20 && seen == 0; c++) begin
            @(negedge clk);
            if (done[1]) seen = 1;
        end
        chk("t4_done_seen", seen, 1);
        chk("t4_rdata", rdata, 32'h0BAD_F00D);
        req[1] = 1'b0;
        req_write[1] = 1'b0;

        // Reset in the middle of a stalled ACCESS
        @(negedge clk);
        slv_wait = 1000;
        req_addr[1*AW +: AW] = 32'h4000_0000;
        req[1] = 1'b1;
        seen = 0;
        for (int c = 0; c < 20 && seen == 0; c++) begin
            @(negedge clk);
            if (apb.PENABLE) seen = 1;
        end
        chk("t5_access_reached", seen, 1);
        req_addr[0 +: AW]    = 32'h5000_0000;
        req_addr[3*AW +: AW] = 32'h5000_0030;
        req_addr[2*AW +: AW] = 32'h5000_0020;
        req_write = '0;
        req[0] = 1'b1;
        req[3] = 1'b1;
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("t5_rst_PSEL", apb.PSEL, 1'b0);
        chk("t5_rst_PENABLE", apb.PENABLE, 1'b0);
        chk("t5_rst_gnt", gnt, 4'b0000);
        chk("t5_rst_done", done, 4'b0000);
        @(negedge clk);
        chk("t5_no_done", done, 4'b0000);
        #1 rst = 1'b0;
        slv_wait = 0;
        slv_rdata = 32'h7777_0000;
        req[2] = 1'b1;

        // All four requesters held high: order 0,1,2,3,... every third cycle
        prevg = '0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (gnt != 4'b0000 && prevg == 4'b0000) begin
                for (int b = 0; b < NREQ; b++) begin
                    if (gnt[b]) gidx.push_back(b);
                end
                gcyc.push_back(c);
            end
            prevg = gnt;
        end
        chk("t6_grant_count_ge12", gidx.size() >= 12, 1'b1);
        if (gidx.size() >= 12) begin
            chk("t6_first_after_reset", gidx[0], 0);
            for (int k = 0; k < 12; k++) begin
                chk($sformatf("t6_order_%0d", k), gidx[k], k % NREQ);
                chk($sformatf("t6_cycle_%0d", k), gcyc[k], 3 * k);
            end
        end

        req = '0;
        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
